// File: rtl/queue_pkg.sv
// Shared types and defaults for the queue drain engine: FSM state encoding,
// data-width / frame-length defaults and the queue capacity.
package queue_pkg;

  localparam int DATA_W_DEFAULT    = 8;
  localparam int MAX_LEN           = 8;
  localparam int FRAME_LEN_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } drain_state_t;

  // Checksum arithmetic: carry out of bit 7 is deliberately dropped.
  function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/frame_checksum.sv
// Per-frame byte counter and mod-256 running sum; pulses frame_done and
// publishes the completed frame's checksum when the last byte is accepted.
module frame_checksum
  import queue_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
  input  logic              clk_10khz,
  input  logic              queue_rst,
  input  logic              xfer,
  input  logic [DATA_W-1:0] xfer_data,
  output logic              frame_done,
  output logic [7:0]        checksum_out
);

  localparam logic [7:0] FRAME_LEN_U8 = 8'(FRAME_LEN);

  logic [7:0] byte_val;
  logic [7:0] cnt_reg;
  logic [7:0] sum_reg;
  logic [7:0] cnt_next;
  logic [7:0] sum_next;
  logic       frame_done_reg;
  logic [7:0] checksum_reg;

  // Only the low byte of the data path contributes to the checksum.
  generate
    if (DATA_W >= 8) begin : g_wide
      assign byte_val = xfer_data[7:0];
    end else begin : g_narrow
      assign byte_val = {{(8 - DATA_W){1'b0}}, xfer_data};
    end
  endgenerate

  assign cnt_next = cnt_reg + 8'd1;
  assign sum_next = add_mod256(sum_reg, byte_val);

  always_ff @(posedge clk_10khz or posedge queue_rst) begin
    if (queue_rst) begin
      cnt_reg        <= '0;
      sum_reg        <= '0;
      frame_done_reg <= 1'b0;
      checksum_reg   <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      if (xfer) begin
        if (cnt_next == FRAME_LEN_U8) begin
          frame_done_reg <= 1'b1;
          checksum_reg   <= sum_next;
          cnt_reg        <= '0;
          sum_reg        <= '0;
        end else begin
          cnt_reg <= cnt_next;
          sum_reg <= sum_next;
        end
      end
    end
  end

  assign frame_done   = frame_done_reg;
  assign checksum_out = checksum_reg;

endmodule

// File: rtl/queue_drain.sv
// Drains bytes from an external queue one at a time (pop, capture, present
// with valid/ready) and hands accepted bytes to the frame checksum logic.
module queue_drain
  import queue_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
  input  logic              clk_10khz,
  input  logic              queue_rst,
  input  logic              enable,
  input  logic [3:0]        len_in,
  input  logic [DATA_W-1:0] queue_data_in,
  output logic              dequeue_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done,
  output logic [7:0]        checksum_out
);

  drain_state_t      state_reg;
  drain_state_t      state_next;
  logic [DATA_W-1:0] out_data_reg;
  logic              xfer;

  always_ff @(posedge clk_10khz or posedge queue_rst) begin
    if (queue_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // enable and len_in are only looked at in IDLE, so a byte in flight always
  // finishes and a mid-sequence enqueue waits for the next decision.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable && (len_in != '0)) state_next = POP;
      POP:     state_next = CAPTURE;
      CAPTURE: state_next = SEND;
      SEND:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The queue presents the popped byte after the edge that sees dequeue_out.
  always_ff @(posedge clk_10khz or posedge queue_rst) begin
    if (queue_rst) begin
      out_data_reg <= '0;
    end else if (state_reg == CAPTURE) begin
      out_data_reg <= queue_data_in;
    end
  end

  assign dequeue_out = (state_reg == POP);
  assign out_valid   = (state_reg == SEND);
  assign out_data    = out_data_reg;
  assign xfer        = (state_reg == SEND) && out_ready;

  frame_checksum #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN)
  ) u_frame_checksum (
    .clk_10khz    (clk_10khz),
    .queue_rst    (queue_rst),
    .xfer         (xfer),
    .xfer_data    (out_data_reg),
    .frame_done   (frame_done),
    .checksum_out (checksum_out)
  );

endmodule

// File: tb/tb_queue_drain.sv
// Scoreboard bench for queue_drain: a behavioural queue model feeds the DUT,
// expected bytes/checksums are queued at issue time and a monitor compares.
`timescale 1us/1ns
module tb_queue_drain;
  import queue_pkg::*;

  localparam int FL = 4;

  logic       clk_10khz = 1'b0;
  logic       queue_rst = 1'b1;
  logic       enable    = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] len_in = 4'd0;
  logic [7:0] queue_data_in = 8'd0;
  logic       dequeue_out;
  logic       out_valid;
  logic [7:0] out_data;
  logic       frame_done;
  logic [7:0] checksum_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] qmem[$];
  logic [7:0] push_q[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] exp_chk[$];
  int         m_cnt = 0;
  logic [7:0] m_sum = 8'd0;
  int         n_xfer = 0;
  int         n_deq  = 0;
  int         n_done = 0;
  bit         flush  = 1'b1;

  always #50 clk_10khz = ~clk_10khz;

  queue_drain #(.DATA_W(8), .FRAME_LEN(FL)) dut (
    .clk_10khz     (clk_10khz),
    .queue_rst     (queue_rst),
    .enable        (enable),
    .len_in        (len_in),
    .queue_data_in (queue_data_in),
    .dequeue_out   (dequeue_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .frame_done    (frame_done),
    .checksum_out  (checksum_out)
  );

  // Behavioural queue: a pop presents the head byte after the sampling edge.
  always @(posedge clk_10khz) begin
    if (flush) begin
      qmem.delete();
      queue_data_in <= 8'd0;
    end else begin
      if (dequeue_out && qmem.size() != 0) queue_data_in <= qmem.pop_front();
      while (push_q.size() != 0 && qmem.size() < MAX_LEN) qmem.push_back(push_q.pop_front());
    end
    len_in <= 4'(qmem.size());
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: one line per accepted byte / completed frame.
  always @(negedge clk_10khz) begin
    if (!queue_rst) begin
      if (out_valid && out_ready) begin
        n_xfer++;
        if (exp_bytes.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_byte actual=%0h required=none", out_data);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_bytes.pop_front()));
        end
      end
      if (frame_done) begin
        n_done++;
        if (exp_chk.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame_done actual=%0h required=none", checksum_out);
        end else begin
          check("checksum_out", 32'(checksum_out), 32'(exp_chk.pop_front()));
        end
      end
      if (dequeue_out) begin
        n_deq++;
        check("dequeue_len_nonzero", 32'(len_in != 4'd0), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_10khz);
      #1;
    end
  endtask

  // Reference model: bytes leave in queue order; every FL bytes close a frame.
  task automatic push_byte(input logic [7:0] b);
    push_q.push_back(b);
    exp_bytes.push_back(b);
    m_sum = m_sum + b;
    m_cnt++;
    if (m_cnt == FL) begin
      exp_chk.push_back(m_sum);
      m_cnt = 0;
      m_sum = 8'd0;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_bytes.size() != 0 || push_q.size() != 0) && c < budget) begin
      tick(1);
      c++;
    end
    check({name, "_drained"}, 32'(exp_bytes.size()), 32'd0);
    tick(2);
    check({name, "_frames_seen"}, 32'(exp_chk.size()), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dequeue"}, 32'(dequeue_out), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_checksum"}, 32'(checksum_out), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, x0, f0, c, v, issued;
    logic [7:0] held;

    // Reset state
    tick(2);
    check_zero_outputs("reset");
    flush = 1'b0;
    queue_rst = 1'b0;

    // Empty queue with enable high: nothing must be popped
    enable = 1'b1;
    d0 = n_deq;
    v = 0;
    repeat (20) begin
      tick(1);
      if (out_valid) v++;
    end
    check("empty_no_dequeue", 32'(n_deq - d0), 32'd0);
    check("empty_no_valid", 32'(v), 32'd0);
    enable = 1'b0;

    // Preloaded frame 10,20,30,40 with latency probe
    out_ready = 1'b1;
    push_byte(8'h10); push_byte(8'h20); push_byte(8'h30); push_byte(8'h40);
    tick(3);
    d0 = n_deq;
    f0 = n_done;
    enable = 1'b1;
    tick(1);
    check("latency_dequeue", 32'(dequeue_out), 32'd1);
    tick(2);
    check("latency_valid", 32'(out_valid), 32'd1);
    wait_drain("frame_a0", 100);
    check("frame_a0_dequeues", 32'(n_deq - d0), 32'd4);
    check("frame_a0_done_count", 32'(n_done - f0), 32'd1);
    check("frame_a0_checksum", 32'(checksum_out), 32'hA0);

    // Wrapping sum
    push_byte(8'hFF); push_byte(8'h02); push_byte(8'h00); push_byte(8'h01);
    wait_drain("wrap", 100);
    check("wrap_checksum", 32'(checksum_out), 32'h02);

    // Backpressure in SEND
    out_ready = 1'b0;
    push_byte(8'h55); push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
    c = 0;
    while (!out_valid && c < 20) begin
      tick(1);
      c++;
    end
    check("stall_reached_send", 32'(out_valid), 32'd1);
    d0 = n_deq;
    held = 8'h55;
    repeat (10) begin
      tick(1);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(held));
    end
    check("stall_no_dequeue", 32'(n_deq - d0), 32'd0);
    out_ready = 1'b1;
    tick(1);
    check("release_valid_low", 32'(out_valid), 32'd0);
    wait_drain("stall", 100);

    // Enable dropped during POP
    enable = 1'b0;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    tick(3);
    d0 = n_deq;
    x0 = n_xfer;
    f0 = n_done;
    enable = 1'b1;
    tick(1);
    check("pop_started", 32'(dequeue_out), 32'd1);
    enable = 1'b0;
    tick(12);
    check("pause_one_dequeue", 32'(n_deq - d0), 32'd1);
    check("pause_one_transfer", 32'(n_xfer - x0), 32'd1);
    check("pause_queue_len", 32'(len_in), 32'd3);
    check("pause_no_frame", 32'(n_done - f0), 32'd0);
    enable = 1'b1;
    wait_drain("pause", 100);
    check("pause_checksum", 32'(checksum_out), 32'hAA);

    // Reset after two of four bytes
    enable = 1'b0;
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3); push_byte(8'hD4);
    tick(3);
    x0 = n_xfer;
    f0 = n_done;
    enable = 1'b1;
    c = 0;
    while ((n_xfer - x0) < 2 && c < 40) begin
      tick(1);
      c++;
    end
    check("pre_reset_two_bytes", 32'(n_xfer - x0), 32'd2);
    #20;
    queue_rst = 1'b1;
    enable = 1'b0;
    flush = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    exp_bytes.delete();
    exp_chk.delete();
    push_q.delete();
    m_cnt = 0;
    m_sum = 8'd0;
    tick(2);
    queue_rst = 1'b0;
    flush = 1'b0;
    check("reset_no_frame_done", 32'(n_done - f0), 32'd0);
    f0 = n_done;
    push_byte(8'h80); push_byte(8'h90); push_byte(8'h07); push_byte(8'h01);
    tick(3);
    enable = 1'b1;
    wait_drain("post_reset", 100);
    check("post_reset_done_count", 32'(n_done - f0), 32'd1);
    check("post_reset_checksum", 32'(checksum_out), 32'h18);

    // Randomized traffic: random enqueue, enable and out_ready
    issued = 0;
    c = 0;
    while (issued < 64 && c < 4000) begin
      if ($urandom_range(0, 2) == 0 && (qmem.size() + push_q.size()) < MAX_LEN - 1) begin
        push_byte(8'($urandom));
        issued++;
      end
      out_ready = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 3) != 0);
      tick(1);
      c++;
    end
    check("random_issued", 32'(issued), 32'd64);
    enable = 1'b1;
    out_ready = 1'b1;
    wait_drain("random", 600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
